// File: rtl/riscv_pkg.sv
// Shared types and limits for the memory port arbiter.
// The FSM state encoding is exposed on a debug port, so IDLE is pinned to zero.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/wait_counter.sv
// Load/decrement down-counter with a zero flag, used to time one memory access.
// A load takes priority over a decrement, and the count holds at zero.
module wait_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and load/store,
// returning read data and producing the pipeline stall requests.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall_F,
   output logic        stall_M,
   output logic [15:0] stall_cnt,
   output logic [1:0]  dbg_state
);

   // Out-of-range LATENCY values are clamped into the legal 1..15 window.
   localparam int LAT_C = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                          ((LATENCY < 1) ? 1 : LATENCY);

   arb_state_t  state_q, state_d;
   logic        last_d_q, last_d_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;
   logic if_done;
   logic d_done;
   logic stall_f;
   logic stall_m;

   wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (CNT_W'(LAT_C)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign if_done = (state_q == BUSY_I) && cnt_zero;
   assign d_done  = (state_q == BUSY_D) && cnt_zero;
   assign cnt_dec = (state_q != IDLE) && !cnt_zero;
   assign stall_f = if_req & ~if_done;
   assign stall_m = d_req & ~d_done;

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Data wins a tie unless it won the previous grant.
            if (d_req && (!if_req || !last_d_q)) begin
               state_d     = BUSY_D;
               last_d_d    = 1'b1;
               mem_en_d    = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               cnt_load    = 1'b1;
            end else if (if_req) begin
               state_d     = BUSY_I;
               last_d_d    = 1'b0;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               cnt_load    = 1'b1;
            end
         end
         BUSY_I, BUSY_D: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((stall_f | stall_m) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Everything is held at zero while reset is low, even before the first edge clears state.
   assign if_ready  = reset & if_done;
   assign d_ready   = reset & d_done;
   assign if_rdata  = (reset && if_done) ? mem_rdata : '0;
   assign d_rdata   = (reset && d_done && !mem_we_q) ? mem_rdata : '0;
   assign mem_en    = reset & mem_en_q;
   assign mem_we    = reset & mem_we_q;
   assign mem_addr  = reset ? mem_addr_q : '0;
   assign mem_wdata = reset ? mem_wdata_q : '0;
   assign stall_F   = reset & stall_f;
   assign stall_M   = reset & stall_m;
   assign stall_cnt = reset ? stall_cnt_q : '0;
   assign dbg_state = reset ? state_q : IDLE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses, a
// negedge monitor pops and compares on every ready pulse and memory strobe.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        sat_phase = 1'b0;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_F;
  logic        stall_M;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  // shared fetch inputs for the LATENCY=1 and LATENCY=15 instances
  logic        l_req = 1'b0;
  logic [31:0] l_addr = '0;
  logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_if_ready, l1_d_ready, l1_mem_en, l1_mem_we, l1_stall_F, l1_stall_M;
  logic [15:0] l1_stall_cnt;
  logic [1:0]  l1_dbg_state;
  logic [31:0] l15_if_rdata, l15_d_rdata, l15_mem_addr, l15_mem_wdata;
  logic        l15_if_ready, l15_d_ready, l15_mem_en, l15_mem_we, l15_stall_F, l15_stall_M;
  logic [15:0] l15_stall_cnt;
  logic [1:0]  l15_dbg_state;

  logic [63:0] exp_if_q[$];   // {rdata, ready cycle}
  logic [63:0] exp_d_q[$];    // {rdata, ready cycle}
  logic [96:0] exp_mem_q[$];  // {mem_en cycle, we, addr, wdata}
  logic [63:0] e_if, e_d;
  logic [96:0] e_mem;

  logic [31:0] mem_model [logic [31:0]];
  logic        rd_v0 = 1'b0, rd_v1 = 1'b0;
  logic [31:0] rd_d0 = '0, rd_d1 = '0;

  mem_port_arbiter #(.LATENCY(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_F(stall_F), .stall_M(stall_M), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.LATENCY(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req(l_req), .if_addr(l_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(32'h0),
    .stall_F(l1_stall_F), .stall_M(l1_stall_M), .stall_cnt(l1_stall_cnt), .dbg_state(l1_dbg_state)
  );

  mem_port_arbiter #(.LATENCY(15), .CNT_W(4)) u_lat15 (
    .clk(clk), .reset(reset),
    .if_req(l_req), .if_addr(l_addr), .if_rdata(l15_if_rdata), .if_ready(l15_if_ready),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(l15_d_rdata), .d_ready(l15_d_ready),
    .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr), .mem_wdata(l15_mem_wdata),
    .mem_rdata(32'h0),
    .stall_F(l15_stall_F), .stall_M(l15_stall_M), .stall_cnt(l15_stall_cnt), .dbg_state(l15_dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model, read data LATENCY=2 after mem_en ----------------
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr] = mem_wdata;
    rd_v0 <= mem_en && !mem_we;
    rd_d0 <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
    rd_v1 <= rd_v0;
    rd_d1 <= rd_d0;
  end
  assign mem_rdata = rd_v1 ? rd_d1 : 32'hBAD0BAD0;

  // ---------------- helpers / driver tasks ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no ready within cycle budget (cycle %0d)", name, cyc);
  endtask

  task automatic expect_mem(input int c, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd);
    exp_mem_q.push_back({32'(c), we, addr, wd});
  endtask

  task automatic drive_if(input logic [31:0] addr, input logic [31:0] data, input int exp_cyc);
    int n = 0;
    if_addr = addr;
    if_req = 1'b1;
    exp_if_q.push_back({data, 32'(exp_cyc)});
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready && n < 64);
    if (!if_ready) timeout_fail("if_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input int exp_cyc);
    int n = 0;
    d_we = we;
    d_addr = addr;
    d_wdata = wd;
    d_req = 1'b1;
    exp_d_q.push_back({exp_rdata, 32'(exp_cyc)});
    do begin
      @(negedge clk);
      n++;
    end while (!d_ready && n < 64);
    if (!d_ready) timeout_fail("d_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!sat_phase && reset) begin
      if (if_ready) begin
        if (exp_if_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL if_ready_unexpected: pulse at cycle %0d, none required", cyc);
        end else begin
          e_if = exp_if_q.pop_front();
          check32("if_rdata", if_rdata, e_if[63:32]);
          check32("if_ready_cycle", 32'(cyc), e_if[31:0]);
        end
      end
      if (d_ready) begin
        if (exp_d_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL d_ready_unexpected: pulse at cycle %0d, none required", cyc);
        end else begin
          e_d = exp_d_q.pop_front();
          check32("d_rdata", d_rdata, e_d[63:32]);
          check32("d_ready_cycle", 32'(cyc), e_d[31:0]);
        end
      end
      if (mem_en) begin
        if (exp_mem_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mem_en_unexpected: strobe at cycle %0d, none required", cyc);
        end else begin
          e_mem = exp_mem_q.pop_front();
          check32("mem_en_cycle", 32'(cyc), e_mem[96:65]);
          check32("mem_we", {31'h0, mem_we}, {31'h0, e_mem[64]});
          check32("mem_addr", mem_addr, e_mem[63:32]);
          if (e_mem[64]) check32("mem_wdata", mem_wdata, e_mem[31:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_errors++;
    n_checks++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    int t_l1;
    int t_l15;
    mem_model[32'h10] = 32'h00500093;
    mem_model[32'h14] = 32'h00A00113;

    // reset state, with both requests high to show outputs are forced low
    reset = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_stall_F", {31'h0, stall_F}, 32'h0);
    check32("rst_stall_M", {31'h0, stall_M}, 32'h0);
    check32("rst_mem_en", {31'h0, mem_en}, 32'h0);
    if_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check32("rst_state", {30'h0, dbg_state}, 32'h0);
    check32("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);

    // store only
    base = cyc;
    expect_mem(base + 1, 1'b1, 32'h100, 32'hDEADBEEF);
    drive_d(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, base + 3);
    d_req = 1'b0;
    check32("stall_cnt_store", {16'h0, stall_cnt}, 32'd3);

    // fetch only
    base = cyc;
    expect_mem(base + 1, 1'b0, 32'h10, 32'h0);
    drive_if(32'h10, 32'h00500093, base + 3);
    if_req = 1'b0;
    check32("stall_cnt_fetch", {16'h0, stall_cnt}, 32'd6);

    // contention: grants D (load), I, D (store)
    base = cyc;
    expect_mem(base + 1, 1'b0, 32'h100, 32'h0);
    expect_mem(base + 5, 1'b0, 32'h14, 32'h0);
    expect_mem(base + 9, 1'b1, 32'h104, 32'h12345678);
    fork
      begin
        drive_d(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, base + 3);
        drive_d(1'b1, 32'h104, 32'h12345678, 32'h0, base + 11);
        d_req = 1'b0;
      end
      begin
        drive_if(32'h14, 32'h00A00113, base + 7);
        if_req = 1'b0;
      end
    join
    check32("stall_cnt_contention", {16'h0, stall_cnt}, 32'd17);

    // reset mid-access: fetch granted at t0, reset low during t2
    base = cyc;
    expect_mem(base + 1, 1'b0, 32'h10, 32'h0);
    if_addr = 32'h10;
    if_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check32("midrst_stall_F", {31'h0, stall_F}, 32'h0);
    check32("midrst_if_ready", {31'h0, if_ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    if_req = 1'b0;
    #1;
    check32("midrst_state", {30'h0, dbg_state}, 32'h0);
    check32("midrst_if_ready_t3", {31'h0, if_ready}, 32'h0);
    check32("midrst_mem_en", {31'h0, mem_en}, 32'h0);
    check32("midrst_mem_addr", mem_addr, 32'h0);
    check32("midrst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    base = cyc;
    expect_mem(base + 1, 1'b0, 32'h14, 32'h0);
    drive_if(32'h14, 32'h00A00113, base + 3);
    if_req = 1'b0;
    check32("stall_cnt_after_rst", {16'h0, stall_cnt}, 32'd3);

    // LATENCY=1 and LATENCY=15 instances
    base = cyc;
    l_addr = 32'h20;
    l_req = 1'b1;
    fork
      begin
        int n = 0;
        while (!l1_if_ready && n < 40) begin
          @(negedge clk);
          n++;
        end
        t_l1 = cyc;
      end
      begin
        int n = 0;
        while (!l15_if_ready && n < 40) begin
          @(negedge clk);
          n++;
        end
        t_l15 = cyc;
      end
    join
    l_req = 1'b0;
    check32("lat1_ready_offset", 32'(t_l1 - base), 32'd2);
    check32("lat15_ready_offset", 32'(t_l15 - base), 32'd16);

    // stall counter saturation with both requesters permanently busy
    @(posedge clk);
    #1;
    sat_phase = 1'b1;
    if_addr = 32'h10;
    d_addr = 32'h100;
    d_we = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check32("stall_cnt_saturated", {16'h0, stall_cnt}, 32'h0000FFFF);
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    sat_phase = 1'b0;
    check32("stall_cnt_held", {16'h0, stall_cnt}, 32'h0000FFFF);

    check32("exp_if_q_drained", 32'(exp_if_q.size()), 32'h0);
    check32("exp_d_q_drained", 32'(exp_d_q.size()), 32'h0);
    check32("exp_mem_q_drained", 32'(exp_mem_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
